// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the FSM state encoding, PC step and default vectors.
`timescale 1ns/1ps
package if_pkg;

    localparam int          STATE_W        = 2;
    localparam logic [31:0] PC_INC         = 32'd4;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

    typedef enum logic [STATE_W-1:0] {
        ST_BOOT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_STALL    = 2'd2,
        ST_REDIRECT = 2'd3
    } if_state_e;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_sequencer_pc_next_sel.sv
// Next-PC priority mux: exception > branch > jump > stall hold > pc+4.
// Also flags whether the selected source is a redirect.
`timescale 1ns/1ps
module pc_next_sel
    import if_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] i_pc,
    input  logic        i_exc,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_stall,
    output logic [31:0] o_next_pc,
    output logic        o_redirect
);

    always_comb begin
        o_next_pc  = i_pc + PC_INC;
        o_redirect = 1'b0;
        if (i_exc) begin
            o_next_pc  = align_word(EXC_VECTOR);
            o_redirect = 1'b1;
        end else if (i_branch_taken) begin
            o_next_pc  = align_word(i_branch_target);
            o_redirect = 1'b1;
        end else if (i_jump) begin
            o_next_pc  = align_word(i_jump_target);
            o_redirect = 1'b1;
        end else if (i_stall) begin
            o_next_pc  = i_pc;
        end
    end

endmodule

// File: rtl/if_sequencer.sv
// Fetch-stage controller: owns the PC, drives the 1-cycle instruction memory,
// and produces IF/ID write-enable, flush and valid plus fetch/bubble counters.
`timescale 1ns/1ps
module if_sequencer
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR  = DEF_EXC_VECTOR,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [31:0]        branch_target_i,
    input  logic               jump_i,
    input  logic [31:0]        jump_target_i,
    input  logic               exc_i,
    output logic [31:0]        pc_o,
    output logic               imem_en_o,
    output logic [31:0]        ifid_pc_o,
    output logic               ifid_valid_o,
    output logic               ifid_we_o,
    output logic               ifid_flush_o,
    output logic [STATE_W-1:0] state_o,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        bubble_cnt_o
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    if_state_e   r_state;
    if_state_e   w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inflight_pc;
    logic        r_inflight_v;
    logic [3:0]  r_boot_cnt;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    logic [31:0] w_next_pc;
    logic        w_redirect_req;
    logic        w_active;
    logic        w_redirect;
    logic        w_advance;

    pc_next_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_pc_next_sel (
        .i_pc            (r_pc),
        .i_exc           (exc_i),
        .i_branch_taken  (branch_taken_i),
        .i_branch_target (branch_target_i),
        .i_jump          (jump_i),
        .i_jump_target   (jump_target_i),
        .i_stall         (stall_i),
        .o_next_pc       (w_next_pc),
        .o_redirect      (w_redirect_req)
    );

    // Requests are ignored while booting; a redirect overrides a stall.
    assign w_active   = (r_state != ST_BOOT);
    assign w_redirect = w_active & w_redirect_req;
    assign w_advance  = w_redirect | ~stall_i;

    // Memory enable must follow stall_i in the same cycle so the memory
    // output holds the instruction that IF/ID is refusing to take.
    assign imem_en_o    = w_active & w_advance;
    assign ifid_we_o    = ~w_active | w_advance;
    assign ifid_flush_o = w_redirect;
    assign ifid_valid_o = r_inflight_v & ~w_redirect;

    assign pc_o         = r_pc;
    assign ifid_pc_o    = r_inflight_pc;
    assign state_o      = r_state;
    assign fetch_cnt_o  = r_fetch_cnt;
    assign bubble_cnt_o = r_bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: begin
                if (r_boot_cnt == BOOT_LAST) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                if (w_redirect) begin
                    w_state_nxt = ST_REDIRECT;
                end else if (stall_i) begin
                    w_state_nxt = ST_STALL;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight_pc <= 32'd0;
            r_inflight_v  <= 1'b0;
            r_boot_cnt    <= 4'd0;
        end else if (!w_active) begin
            r_boot_cnt <= r_boot_cnt + 4'd1;
        end else begin
            r_pc <= w_next_pc;
            if (w_advance) begin
                // A redirect squashes the fetch issued this cycle.
                r_inflight_pc <= r_pc;
                r_inflight_v  <= ~w_redirect;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else if (ifid_we_o) begin
            if (ifid_valid_o) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end else begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_sequencer.sv
// Testbench for if_sequencer: directed fetch/branch/stall/exception/wrap cases
// followed by random request traffic checked against a program-order model.
`timescale 1ns/1ps
module tb_if_sequencer;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC = 32'h0000_0080;
    localparam int          BOOT_N  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        exc_i;
    logic [31:0] pc_o;
    logic        imem_en_o;
    logic [31:0] ifid_pc_o;
    logic        ifid_valid_o;
    logic        ifid_we_o;
    logic        ifid_flush_o;
    logic [1:0]  state_o;
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;

    always #5 clk = ~clk;

    if_sequencer #(
        .RESET_PC    (RST_PC),
        .EXC_VECTOR  (EXC_VEC),
        .BOOT_CYCLES (BOOT_N)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .exc_i           (exc_i),
        .pc_o            (pc_o),
        .imem_en_o       (imem_en_o),
        .ifid_pc_o       (ifid_pc_o),
        .ifid_valid_o    (ifid_valid_o),
        .ifid_we_o       (ifid_we_o),
        .ifid_flush_o    (ifid_flush_o),
        .state_o         (state_o),
        .fetch_cnt_o     (fetch_cnt_o),
        .bubble_cnt_o    (bubble_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: boot countdown, next fetch address, whether the
    // memory output holds a live instruction, and the program-order address
    // the next delivered instruction must carry.
    int          m_boot_left;
    logic [31:0] m_pc;
    logic        m_out_v;
    logic [31:0] m_expect_next;
    logic [31:0] m_fc;
    logic [31:0] m_bc;
    logic [1:0]  m_state;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot_left   = BOOT_N;
        m_pc          = RST_PC;
        m_out_v       = 1'b0;
        m_expect_next = RST_PC;
        m_fc          = 32'd0;
        m_bc          = 32'd0;
        m_state       = 2'd0;
    endtask

    task automatic clear_inputs();
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'd0;
        jump_i          = 1'b0;
        jump_target_i   = 32'd0;
        exc_i           = 1'b0;
    endtask

    // Compare all outputs for the current cycle, then advance the model
    // across the coming rising edge.
    task automatic check_cycle();
        logic        redir;
        logic        e_en, e_we, e_fl, e_v;
        logic [31:0] e_pc, tgt;
        logic [1:0]  e_st;
        redir = 1'b0;
        if (m_boot_left > 0) begin
            e_pc = RST_PC; e_en = 1'b0; e_we = 1'b1; e_fl = 1'b0; e_v = 1'b0; e_st = 2'd0;
        end else begin
            redir = exc_i | branch_taken_i | jump_i;
            e_fl  = redir;
            e_we  = redir | ~stall_i;
            e_en  = e_we;
            e_v   = m_out_v & ~redir;
            e_st  = m_state;
            e_pc  = m_pc;
        end
        check_eq("pc_o", pc_o, e_pc);
        check_eq("imem_en", {31'd0, imem_en_o}, {31'd0, e_en});
        check_eq("ifid_we", {31'd0, ifid_we_o}, {31'd0, e_we});
        check_eq("ifid_flush", {31'd0, ifid_flush_o}, {31'd0, e_fl});
        check_eq("ifid_valid", {31'd0, ifid_valid_o}, {31'd0, e_v});
        check_eq("state", {30'd0, state_o}, {30'd0, e_st});
        check_eq("fetch_cnt", fetch_cnt_o, m_fc);
        check_eq("bubble_cnt", bubble_cnt_o, m_bc);
        if (e_v) check_eq("ifid_pc_order", ifid_pc_o, m_expect_next);

        if (e_we) begin
            if (e_v) begin
                m_fc          = m_fc + 1;
                m_expect_next = m_expect_next + 32'd4;
            end else begin
                m_bc = m_bc + 1;
            end
        end
        if (m_boot_left > 0) begin
            m_boot_left--;
            if (m_boot_left == 0) m_state = 2'd1;
        end else if (redir) begin
            tgt           = exc_i ? EXC_VEC : (branch_taken_i ? branch_target_i : jump_target_i);
            tgt           = tgt & 32'hFFFF_FFFC;
            m_pc          = tgt;
            m_expect_next = tgt;
            m_out_v       = 1'b0;
            m_state       = 2'd3;
        end else if (stall_i) begin
            m_state = 2'd2;
        end else begin
            m_out_v = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_state = 2'd1;
        end
    endtask

    task automatic step_set(input logic st, input logic br, input logic [31:0] bt,
                            input logic jp, input logic [31:0] jt, input logic ex);
        @(negedge clk);
        stall_i = st; branch_taken_i = br; branch_target_i = bt;
        jump_i = jp; jump_target_i = jt; exc_i = ex;
        #1;
        check_cycle();
    endtask

    task automatic step_idle();
        step_set(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic step_rand();
        logic [31:0] jt;
        jt = $urandom;
        if ($urandom_range(7) == 0) jt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        step_set($urandom_range(99) < 20, $urandom_range(99) < 8, $urandom,
                 $urandom_range(99) < 8, jt, $urandom_range(99) < 3);
    endtask

    // Asserts reset between clock edges and checks outputs settle at once.
    task automatic assert_reset_check(input string tag);
        rst = 1'b1;
        clear_inputs();
        #1;
        check_eq({tag, "_pc"}, pc_o, RST_PC);
        check_eq({tag, "_en"}, {31'd0, imem_en_o}, 32'd0);
        check_eq({tag, "_ifid_pc"}, ifid_pc_o, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, ifid_valid_o}, 32'd0);
        check_eq({tag, "_we"}, {31'd0, ifid_we_o}, 32'd1);
        check_eq({tag, "_flush"}, {31'd0, ifid_flush_o}, 32'd0);
        check_eq({tag, "_state"}, {30'd0, state_o}, 32'd0);
        check_eq({tag, "_fcnt"}, fetch_cnt_o, 32'd0);
        check_eq({tag, "_bcnt"}, bubble_cnt_o, 32'd0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        #2;
        assert_reset_check("rst_init");
        release_reset();

        // Boot: first fetch of RESET_PC in cycle 2, valid in cycle 3.
        repeat (4) step_idle();
        check_eq("boot_first_pc", ifid_pc_o, 32'h0);
        check_eq("boot_first_v", {31'd0, ifid_valid_o}, 32'd1);
        check_eq("boot_pc4", pc_o, 32'h4);

        // Taken branch to 0x40 while pc_q = 0x10.
        repeat (2) step_idle();
        step_set(1'b0, 1'b1, 32'h40, 1'b0, 32'd0, 1'b0);
        check_eq("br_pc_at_redirect", pc_o, 32'h10);
        check_eq("br_flush", {31'd0, ifid_flush_o}, 32'd1);
        step_idle();
        check_eq("br_target_issued", pc_o, 32'h40);
        check_eq("br_gap_invalid", {31'd0, ifid_valid_o}, 32'd0);
        step_idle();
        check_eq("br_target_pc", ifid_pc_o, 32'h40);
        check_eq("br_target_v", {31'd0, ifid_valid_o}, 32'd1);

        // Jump to 0x20, then a 3-cycle stall at pc_q = 0x20.
        step_set(1'b0, 1'b0, 32'd0, 1'b1, 32'h20, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step_set(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
            check_eq("stall_pc_hold", pc_o, 32'h20);
            check_eq("stall_we_low", {31'd0, ifid_we_o}, 32'd0);
        end
        step_idle();
        check_eq("stall_resume_pc", pc_o, 32'h20);
        step_idle();
        check_eq("stall_stream0", ifid_pc_o, 32'h20);
        step_idle();
        check_eq("stall_stream1", ifid_pc_o, 32'h24);

        // Exception, branch and stall together: exception wins.
        step_set(1'b1, 1'b1, 32'h300, 1'b0, 32'd0, 1'b1);
        check_eq("exc_flush", {31'd0, ifid_flush_o}, 32'd1);
        step_idle();
        check_eq("exc_vector_pc", pc_o, 32'h80);
        check_eq("exc_state", {30'd0, state_o}, 32'd3);

        // PC wrap and misaligned jump target.
        step_set(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step_idle();
        check_eq("wrap_top", pc_o, 32'hFFFF_FFFC);
        step_idle();
        check_eq("wrap_zero", pc_o, 32'h0);
        step_set(1'b0, 1'b0, 32'd0, 1'b1, 32'h103, 1'b0);
        step_idle();
        check_eq("jmp_align", pc_o, 32'h100);
        check_eq("jmp_state", {30'd0, state_o}, 32'd3);

        // Reset asserted mid-REDIRECT, then boot replays.
        #1;
        assert_reset_check("rst_mid");
        release_reset();
        repeat (4) step_idle();
        check_eq("replay_first_pc", ifid_pc_o, 32'h0);

        // Random traffic with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(negedge clk);
                #2;
                assert_reset_check("rst_rand");
                release_reset();
            end
            step_rand();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
